matmul_seq_ctrl: RTL and testbench

//  Sequencer for the matmul peripheral datapath. It computes C = A x B for square NxN

---
 rtl/matmul_seq_ctrl_if.sv | 41 ++++
 rtl/matmul_seq_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_seq_ctrl_if.sv
// Bundles the sequencer's control-register side and buffer/MAC side signals.
// No storage and no latency of its own; it only carries nets between modules.
// Backpressure is stall: the master raises it to freeze operand issue and C writes.
interface matmul_seq_ctrl_if #(
    parameter int DIM_W  = 4,
    parameter int ADDR_W = 6
);
    // control register side
    logic              start;
    logic              abort;
    logic [DIM_W-1:0]  dim;
    logic              irq_en;
    logic              irq_clr;
    logic              busy;
    logic              done;
    logic              err;
    logic              irq;
    // buffer / MAC side
    logic              stall;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic              rd_en;
    logic              mac_en;
    logic              mac_clr;
    logic [ADDR_W-1:0] c_addr;
    logic              c_we;

    // Register decoder and buffer owner: drive commands, observe the sequencer.
    modport master (
        output start, abort, dim, irq_en, irq_clr, stall,
        input  busy, done, err, irq,
        input  a_addr, b_addr, rd_en, mac_en, mac_clr, c_addr, c_we
    );

    // The sequencer itself.
    modport slave (
        input  start, abort, dim, irq_en, irq_clr, stall,
        output busy, done, err, irq,
        output a_addr, b_addr, rd_en, mac_en, mac_clr, c_addr, c_we
    );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for C = A x B on NxN row-major buffers: issues operand reads, MAC strobes, C writes.
// Per C element: N issue cycles, MAC_LAT+1 drain cycles, 1 write cycle; done pulse after the last write.
// stall freezes operand issue and the C write; the drain counter and the MAC pipeline keep moving.
module matmul_seq_ctrl #(
    parameter int MAX_N   = 8,
    parameter int DIM_W   = 4,
    parameter int ADDR_W  = 6,
    parameter int MAC_LAT = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    matmul_seq_ctrl_if.slave     bus
);

    localparam int DRN_W = $clog2(MAC_LAT + 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [DIM_W-1:0]  n_q;
    logic [DIM_W-1:0]  i_q;
    logic [DIM_W-1:0]  j_q;
    logic [DIM_W-1:0]  k_q;
    logic [DRN_W-1:0]  drn_q;
    logic              mac_en_q;
    logic              k0_q;
    logic              err_q;
    logic              irq_q;

    logic [DIM_W-1:0]  n_m1;
    logic              abort_now;
    logic              dim_bad;
    logic              last_k;
    logic              last_j;
    logic              last_i;
    logic              drain_end;
    logic              issue;
    logic              write;
    logic              done;
    logic              chk_ok;
    logic              chk_bad;
    logic              irq_set;

    assign n_m1      = n_q - DIM_W'(1);
    assign abort_now = bus.abort && (state_q != IDLE);
    assign dim_bad   = (n_q == '0) || (n_q > DIM_W'(MAX_N));
    assign last_k    = (k_q == n_m1);
    assign last_j    = (j_q == n_m1);
    assign last_i    = (i_q == n_m1);
    assign drain_end = (drn_q == DRN_W'(MAC_LAT));

    // Next-state and per-cycle strobes; an abort overrides every state except IDLE.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        write   = 1'b0;
        done    = 1'b0;
        chk_ok  = 1'b0;
        chk_bad = 1'b0;
        if (abort_now) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // abort while idle drops a coincident start
                    if (bus.start && !bus.abort) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (dim_bad) begin
                        chk_bad = 1'b1;
                        state_d = IDLE;
                    end else begin
                        chk_ok  = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!bus.stall) begin
                        issue = 1'b1;
                        if (last_k) begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_end) begin
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (!bus.stall) begin
                        write   = 1'b1;
                        state_d = (last_i && last_j) ? DONE : RUN;
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dimension latch and (i,j,k) loop counters: k walks the dot product, j then i walk C.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            n_q <= '0;
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            if (state_q == IDLE && bus.start && !bus.abort) begin
                n_q <= bus.dim;
            end
            if (chk_ok) begin
                i_q <= '0;
                j_q <= '0;
                k_q <= '0;
            end else if (issue) begin
                k_q <= k_q + DIM_W'(1);
            end else if (write) begin
                k_q <= '0;
                if (last_j) begin
                    j_q <= '0;
                    i_q <= i_q + DIM_W'(1);
                end else begin
                    j_q <= j_q + DIM_W'(1);
                end
            end
        end
    end

    // Drain counter: free-runs through DRAIN so the accumulator has settled before the write.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            drn_q <= '0;
        end else if (state_q == DRAIN && !abort_now && !drain_end) begin
            drn_q <= drn_q + DRN_W'(1);
        end else begin
            drn_q <= '0;
        end
    end

    // Operand pipeline: buffer data lands one cycle after the read, together with the k==0 flag.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            mac_en_q <= 1'b0;
            k0_q     <= 1'b0;
        end else if (abort_now) begin
            mac_en_q <= 1'b0;
            k0_q     <= 1'b0;
        end else begin
            mac_en_q <= issue;
            k0_q     <= (k_q == '0);
        end
    end

    assign irq_set = bus.irq_en && (done || chk_bad);

    // Sticky dimension error and level interrupt; a set beats a same-cycle clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            err_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (chk_bad) begin
                err_q <= 1'b1;
            end else if (chk_ok) begin
                err_q <= 1'b0;
            end
            if (irq_set) begin
                irq_q <= 1'b1;
            end else if (bus.irq_clr) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign bus.a_addr  = ADDR_W'(i_q) * ADDR_W'(n_q) + ADDR_W'(k_q);
    assign bus.b_addr  = ADDR_W'(k_q) * ADDR_W'(n_q) + ADDR_W'(j_q);
    assign bus.c_addr  = ADDR_W'(i_q) * ADDR_W'(n_q) + ADDR_W'(j_q);
    assign bus.rd_en   = issue;
    assign bus.mac_en  = mac_en_q;
    assign bus.mac_clr = mac_en_q && k0_q;
    assign bus.c_we    = write;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done;
    assign bus.err     = err_q;
    assign bus.irq     = irq_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Randomized and directed bench for the matmul sequencer against a schedule model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// The model derives every strobe cycle from the loop rules and the stall pattern.
module tb_matmul_seq_ctrl;

    localparam int MAX_N   = 8;
    localparam int DIM_W   = 4;
    localparam int ADDR_W  = 6;
    localparam int MAC_LAT = 2;
    localparam int TL      = 2048;

    logic clk;
    logic rst_n;

    matmul_seq_ctrl_if #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) bus ();

    matmul_seq_ctrl #(
        .MAX_N   (MAX_N),
        .DIM_W   (DIM_W),
        .ADDR_W  (ADDR_W),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // expected per-cycle behaviour of one job, indexed by cycle relative to the start pulse
    bit stall_pat [TL];
    bit e_rd  [TL];
    bit e_mac [TL];
    bit e_clr [TL];
    bit e_we  [TL];
    int e_a   [TL];
    int e_b   [TL];
    int e_c   [TL];
    int e_done;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        vectors++;
        if (obs !== 32'(exp)) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Lay out the whole job: every unstalled RUN slot issues the next (i,j,k) term,
    // the write waits MAC_LAT+1 cycles after the last term plus any stall, done follows it.
    function automatic void plan(input int n);
        int t;
        for (int x = 0; x < TL; x++) begin
            e_rd[x] = 0; e_mac[x] = 0; e_clr[x] = 0; e_we[x] = 0;
            e_a[x] = 0; e_b[x] = 0; e_c[x] = 0;
        end
        t = 2;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                for (int k = 0; k < n; k++) begin
                    while (stall_pat[t]) t++;
                    e_rd[t]    = 1;
                    e_a[t]     = i * n + k;
                    e_b[t]     = k * n + j;
                    e_mac[t+1] = 1;
                    e_clr[t+1] = (k == 0);
                    t++;
                end
                t += MAC_LAT + 1;
                while (stall_pat[t]) t++;
                e_we[t] = 1;
                e_c[t]  = i * n + j;
                t++;
            end
        end
        e_done = t;
    endfunction

    function automatic void clear_stall();
        for (int x = 0; x < TL; x++) stall_pat[x] = 0;
    endfunction

    task automatic idle_inputs();
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.irq_clr = 1'b0;
        bus.stall   = 1'b0;
    endtask

    task automatic run_job(input int n, input bit ien, input int abort_at, input bit clr_on_done,
                           output int obs_done, output int obs_we);
        int last_t;
        bit exp_irq;
        obs_done = -1;
        obs_we   = 0;
        plan(n);
        // drop any interrupt left over from an earlier job
        @(negedge clk);
        idle_inputs();
        bus.irq_clr = 1'b1;
        last_t = (abort_at >= 0) ? abort_at + 4 : e_done + 2;
        for (int t = 0; t <= last_t; t++) begin
            @(negedge clk);
            bus.start   = (t == 0);
            bus.dim     = DIM_W'(n);
            bus.irq_en  = ien;
            bus.stall   = stall_pat[t];
            bus.abort   = (t == abort_at);
            bus.irq_clr = clr_on_done && (t == e_done || t == e_done + 1);
            #1;
            if (bus.done === 1'b1 && obs_done < 0) obs_done = t;
            if (bus.c_we === 1'b1) obs_we++;
            if (abort_at >= 0 && t > abort_at) begin
                check("abt_rd_en", bus.rd_en, 0);
                check("abt_mac_en", bus.mac_en, 0);
                check("abt_mac_clr", bus.mac_clr, 0);
                check("abt_c_we", bus.c_we, 0);
                check("abt_done", bus.done, 0);
                check("abt_busy", bus.busy, 0);
                check("abt_irq", bus.irq, 0);
            end else if (t != abort_at) begin
                check("rd_en", bus.rd_en, e_rd[t]);
                if (e_rd[t]) begin
                    check("a_addr", bus.a_addr, e_a[t]);
                    check("b_addr", bus.b_addr, e_b[t]);
                end
                check("mac_en", bus.mac_en, e_mac[t]);
                check("mac_clr", bus.mac_clr, e_clr[t]);
                check("c_we", bus.c_we, e_we[t]);
                if (e_we[t]) check("c_addr", bus.c_addr, e_c[t]);
                check("done", bus.done, (t == e_done));
                check("busy", bus.busy, (t >= 1 && t <= e_done));
                if (t >= 2) check("err", bus.err, 0);
                exp_irq = ien && (t > e_done) && !(clr_on_done && t > e_done + 1);
                check("irq", bus.irq, exp_irq);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic run_bad(input int d, input bit ien);
        @(negedge clk);
        idle_inputs();
        bus.irq_clr = 1'b1;
        for (int t = 0; t <= 5; t++) begin
            @(negedge clk);
            bus.start   = (t == 0);
            bus.dim     = DIM_W'(d);
            bus.irq_en  = ien;
            bus.irq_clr = 1'b0;
            #1;
            check("bad_rd_en", bus.rd_en, 0);
            check("bad_done", bus.done, 0);
            if (t == 1) check("bad_busy_chk", bus.busy, 1);
            if (t >= 2) begin
                check("bad_err", bus.err, 1);
                check("bad_busy", bus.busy, 0);
                check("bad_irq", bus.irq, ien);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int w;
        int n;
        rst_n      = 1'b0;
        bus.dim    = '0;
        bus.irq_en = 1'b0;
        idle_inputs();
        clear_stall();
        #12;
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_mac_en", bus.mac_en, 0);
        check("rst_mac_clr", bus.mac_clr, 0);
        check("rst_c_we", bus.c_we, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_irq", bus.irq, 0);
        check("rst_a_addr", bus.a_addr, 0);
        check("rst_b_addr", bus.b_addr, 0);
        check("rst_c_addr", bus.c_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // N=2 reference run: done lands on cycle 26
        clear_stall();
        run_job(2, 1'b0, -1, 1'b0, d, w);
        check("t1_done_cycle", d, 26);
        check("t1_we_count", w, 4);

        // dimension errors raise err and irq without any issue; a good start clears err
        run_bad(0, 1'b1);
        run_bad(9, 1'b1);
        run_job(2, 1'b0, -1, 1'b0, d, w);
        check("t2_done_cycle", d, 26);

        // N=1 with three RUN stalls and two WRITE stalls
        clear_stall();
        for (int x = 2; x <= 4; x++) stall_pat[x] = 1;
        stall_pat[9]  = 1;
        stall_pat[10] = 1;
        run_job(1, 1'b0, -1, 1'b0, d, w);
        check("t3_done_cycle", d, 12);
        check("t3_we_count", w, 1);

        // abort mid-run, then a fresh job completes
        clear_stall();
        run_job(3, 1'b1, 10, 1'b0, d, w);
        check("t4_no_done", d, -1);
        run_job(3, 1'b1, -1, 1'b0, d, w);
        check("t4_done_cycle", d, 2 + 9 * (3 + MAC_LAT + 2));

        // interrupt clear coinciding with done loses to the set
        run_job(1, 1'b1, -1, 1'b1, d, w);
        check("t5_we_count", w, 1);

        // randomized dimensions, stall patterns and interrupt enables
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, MAX_N);
            for (int x = 0; x < TL; x++) stall_pat[x] = ($urandom_range(0, 99) < 20);
            for (int x = 1200; x < TL; x++) stall_pat[x] = 0;
            run_job(n, 1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)), d, w);
            check("rnd_we_count", w, n * n);
        end

        // reset pulled during the WRITE cycle of an N=1 job
        clear_stall();
        plan(1);
        bus.irq_en = 1'b1;
        for (int t = 0; t <= 6; t++) begin
            @(negedge clk);
            bus.start = (t == 0);
            bus.dim   = DIM_W'(1);
            #1;
        end
        check("t6_pre_we", bus.c_we, e_we[6]);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_c_we", bus.c_we, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_done", bus.done, 0);
        check("t6_rst_mac_en", bus.mac_en, 0);
        check("t6_rst_rd_en", bus.rd_en, 0);
        check("t6_rst_c_addr", bus.c_addr, 0);
        check("t6_rst_irq", bus.irq, 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            #1;
            check("t6_post_c_we", bus.c_we, 0);
            check("t6_post_done", bus.done, 0);
            check("t6_post_busy", bus.busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
